// File: rtl/dezigzag_dequant_pkg.sv
// Shared constants for the de-zigzag / dequantise front end of the 8x8 IDCT path.
package dezigzag_dequant_pkg;
  localparam int unsigned BLK_N      = 64;
  localparam int unsigned ROW_N      = 8;
  localparam int unsigned COEF_W_DEF = 16;
  localparam int unsigned Q_W_DEF    = 8;
  localparam int unsigned OUT_W_DEF  = 32;

  typedef enum logic {ST_LOAD, ST_EMIT} state_e;

  // Zig-zag scan position -> natural row-major index.
  localparam logic [5:0] ZZ [BLK_N] = '{
     0,  1,  8, 16,  9,  2,  3, 10,
    17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34,
    27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36,
    29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46,
    53, 60, 61, 54, 47, 55, 62, 63
  };
endpackage

// File: rtl/dezigzag_dequant_if.sv
// Coefficient-in / row-out bus between entropy decoder, dezigzag_dequant and rowidct.
interface dezigzag_dequant_if
  import dezigzag_dequant_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned Q_W    = Q_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
);
  logic                     qt_we;
  logic [5:0]               qt_addr;
  logic [Q_W-1:0]           qt_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [5:0]               in_pos;
  logic signed [COEF_W-1:0] in_coef;
  logic                     in_last;
  logic                     row_valid;
  logic                     row_ready;
  logic [2:0]               row_idx;
  logic                     row_last;
  logic signed [OUT_W-1:0]  x0, x1, x2, x3, x4, x5, x6, x7;

  modport master (
    output qt_we, qt_addr, qt_data, in_valid, in_pos, in_coef, in_last, row_ready,
    input  in_ready, row_valid, row_idx, row_last, x0, x1, x2, x3, x4, x5, x6, x7
  );

  modport slave (
    input  qt_we, qt_addr, qt_data, in_valid, in_pos, in_coef, in_last, row_ready,
    output in_ready, row_valid, row_idx, row_last, x0, x1, x2, x3, x4, x5, x6, x7
  );
endinterface

// File: rtl/dezigzag_dequant_quant_table_ram.sv
// 64-entry quant table indexed in zig-zag order: synchronous write, asynchronous read, no reset.
module quant_table_ram
  import dezigzag_dequant_pkg::*;
#(
  parameter int unsigned Q_W = Q_W_DEF
) (
  input  logic           clk,
  input  logic           we_i,
  input  logic [5:0]     waddr_i,
  input  logic [Q_W-1:0] wdata_i,
  input  logic [5:0]     raddr_i,
  output logic [Q_W-1:0] rdata_o
);
  logic [Q_W-1:0] mem_q [BLK_N];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/dezigzag_dequant.sv
// Dequantises sparse zig-zag coefficients into a natural-order 8x8 buffer and emits it row by row.
module dezigzag_dequant
  import dezigzag_dequant_pkg::*;
#(
  parameter int unsigned COEF_W = COEF_W_DEF,
  parameter int unsigned Q_W    = Q_W_DEF,
  parameter int unsigned OUT_W  = OUT_W_DEF
) (
  input logic               clk,
  input logic               rst,
  dezigzag_dequant_if.slave bus
);
  state_e                    state_q, state_d;
  logic [BLK_N-1:0]          mask_q, mask_d;
  logic [2:0]                row_q, row_d;
  logic signed [OUT_W-1:0]   buf_q [BLK_N];
  logic [Q_W-1:0]            q_rd;
  logic                      accept;
  logic [5:0]                nat;
  logic signed [COEF_W+Q_W:0] prod;
  logic signed [OUT_W-1:0]   prod_ext;
  logic signed [OUT_W-1:0]   xs [ROW_N];

  quant_table_ram #(.Q_W(Q_W)) u_qtab (
    .clk     (clk),
    .we_i    (bus.qt_we),
    .waddr_i (bus.qt_addr),
    .wdata_i (bus.qt_data),
    .raddr_i (bus.in_pos),
    .rdata_o (q_rd)
  );

  assign nat      = ZZ[bus.in_pos];
  assign prod     = bus.in_coef * $signed({1'b0, q_rd});
  assign prod_ext = OUT_W'(prod);

  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    row_d         = row_q;
    accept        = 1'b0;
    bus.in_ready  = 1'b0;
    bus.row_valid = 1'b0;
    case (state_q)
      ST_LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          accept      = 1'b1;
          mask_d[nat] = 1'b1;
          if (bus.in_last) state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        bus.row_valid = 1'b1;
        if (bus.row_ready) begin
          if (row_q == 3'd7) begin
            row_d   = '0;
            mask_d  = '0;
            state_d = ST_LOAD;
          end else begin
            row_d = row_q + 3'd1;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      mask_q  <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      row_q   <= row_d;
    end
  end

  // Buffer has no reset: stale entries are hidden by the written-mask.
  always_ff @(posedge clk) begin
    if (accept && !rst) buf_q[nat] <= prod_ext;
  end

  always_comb begin
    for (int unsigned c = 0; c < ROW_N; c++) begin
      xs[c] = '0;
      if (state_q == ST_EMIT && mask_q[{row_q, 3'(c)}]) xs[c] = buf_q[{row_q, 3'(c)}];
    end
  end

  assign bus.row_idx  = row_q;
  assign bus.row_last = (state_q == ST_EMIT) && (row_q == 3'd7);
  assign bus.x0 = xs[0];
  assign bus.x1 = xs[1];
  assign bus.x2 = xs[2];
  assign bus.x3 = xs[3];
  assign bus.x4 = xs[4];
  assign bus.x5 = xs[5];
  assign bus.x6 = xs[6];
  assign bus.x7 = xs[7];
endmodule

// File: tb/tb_dezigzag_dequant.sv
// Directed, table-driven bench for dezigzag_dequant with hand-computed expected rows.
module tb_dezigzag_dequant;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  dezigzag_dequant_if #(.COEF_W(16), .Q_W(8), .OUT_W(32)) bus ();

  dezigzag_dequant #(.COEF_W(16), .Q_W(8), .OUT_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic signed [31:0] xs [8];
  always_comb begin
    xs[0] = bus.x0; xs[1] = bus.x1; xs[2] = bus.x2; xs[3] = bus.x3;
    xs[4] = bus.x4; xs[5] = bus.x5; xs[6] = bus.x6; xs[7] = bus.x7;
  end

  longint exp_v [64];

  typedef struct {
    logic [5:0]         pos;
    logic [7:0]         q;
    logic signed [15:0] coef;
    int                 nat;
    longint             val;
  } vec_t;
  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 64; i++) exp_v[i] = 0;
  endtask

  task automatic qt_write(input logic [5:0] a, input logic [7:0] d);
    bus.qt_we = 1'b1; bus.qt_addr = a; bus.qt_data = d;
    tick();
    bus.qt_we = 1'b0;
  endtask

  task automatic send(input logic [5:0] pos, input logic signed [15:0] coef, input logic last);
    check("send in_ready", longint'(bus.in_ready), 1);
    bus.in_valid = 1'b1; bus.in_pos = pos; bus.in_coef = coef; bus.in_last = last;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic check_row(input string tag, input int r);
    check($sformatf("%s r%0d row_valid", tag, r), longint'(bus.row_valid), 1);
    check($sformatf("%s r%0d row_idx", tag, r), longint'(bus.row_idx), longint'(r));
    check($sformatf("%s r%0d row_last", tag, r), longint'(bus.row_last), (r == 7) ? 1 : 0);
    check($sformatf("%s r%0d in_ready", tag, r), longint'(bus.in_ready), 0);
    for (int c = 0; c < 8; c++)
      check($sformatf("%s r%0d x%0d", tag, r, c), longint'(xs[c]), exp_v[8*r+c]);
  endtask

  // Row 0 must be valid on the first call (one cycle after in_last); rows then arrive every cycle.
  task automatic collect(input string tag, input int stall_row, input int abort_row, input bit bogus);
    bus.row_ready = 1'b1;
    if (bogus) begin
      bus.in_valid = 1'b1; bus.in_pos = 6'd0; bus.in_coef = 16'sd100; bus.in_last = 1'b1;
    end
    for (int r = 0; r < 8; r++) begin
      if (r == abort_row) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.row_ready = 1'b0;
        check({tag, " rst row_valid"}, longint'(bus.row_valid), 0);
        check({tag, " rst in_ready"}, longint'(bus.in_ready), 1);
        check({tag, " rst row_idx"}, longint'(bus.row_idx), 0);
        check({tag, " rst x0"}, longint'(xs[0]), 0);
        return;
      end
      if (r == stall_row) begin
        bus.row_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick();
          check_row($sformatf("%s stall%0d", tag, s), r);
        end
        bus.row_ready = 1'b1;
      end
      check_row(tag, r);
      tick();
    end
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.row_ready = 1'b0;
    check({tag, " end in_ready"}, longint'(bus.in_ready), 1);
    check({tag, " end row_valid"}, longint'(bus.row_valid), 0);
    check({tag, " end row_idx"}, longint'(bus.row_idx), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{pos: 6'd0,  q: 8'd1,   coef: 16'sd5,      nat: 0,  val: 5};
    vecs[1] = '{pos: 6'd63, q: 8'd255, coef: 16'sd1,      nat: 63, val: 255};
    vecs[2] = '{pos: 6'd1,  q: 8'd2,   coef: 16'sd3,      nat: 1,  val: 6};
    vecs[3] = '{pos: 6'd10, q: 8'd200, coef: -16'sd300,   nat: 32, val: -60000};
    vecs[4] = '{pos: 6'd3,  q: 8'd255, coef: -16'sd32768, nat: 16, val: -8355840};
    vecs[5] = '{pos: 6'd20, q: 8'd128, coef: 16'sd32767,  nat: 40, val: 4194176};
    vecs[6] = '{pos: 6'd4,  q: 8'd0,   coef: 16'sd1234,   nat: 9,  val: 0};

    bus.qt_we = 1'b0; bus.qt_addr = '0; bus.qt_data = '0;
    bus.in_valid = 1'b0; bus.in_pos = '0; bus.in_coef = '0; bus.in_last = 1'b0;
    bus.row_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset row_valid", longint'(bus.row_valid), 0);
    check("reset in_ready", longint'(bus.in_ready), 1);
    check("reset row_idx", longint'(bus.row_idx), 0);
    check("reset row_last", longint'(bus.row_last), 0);
    check("reset x0", longint'(xs[0]), 0);

    for (int i = 0; i < 64; i++) qt_write(6'(i), 8'd1);

    // Single-pair blocks, including the all-ones table case at pos 0.
    for (int v = 0; v < 7; v++) begin
      qt_write(vecs[v].pos, vecs[v].q);
      send(vecs[v].pos, vecs[v].coef, 1'b1);
      clear_exp();
      exp_v[vecs[v].nat] = vecs[v].val;
      collect($sformatf("vec%0d", v), -1, -1, 1'b0);
    end

    // Two pairs in one block.
    qt_write(6'd1, 8'd2);
    qt_write(6'd2, 8'd3);
    send(6'd1, 16'sd3, 1'b0);
    send(6'd2, -16'sd4, 1'b1);
    clear_exp(); exp_v[1] = 6; exp_v[8] = -12;
    collect("two", -1, -1, 1'b0);

    // Quant write in the accept cycle uses the old entry; the next block sees the new one.
    qt_write(6'd63, 8'd255);
    bus.qt_we = 1'b1; bus.qt_addr = 6'd63; bus.qt_data = 8'd7;
    send(6'd63, 16'sd1, 1'b1);
    bus.qt_we = 1'b0;
    clear_exp(); exp_v[63] = 255;
    collect("qt_same", -1, -1, 1'b0);
    send(6'd63, 16'sd1, 1'b1);
    clear_exp(); exp_v[63] = 7;
    collect("qt_after", -1, -1, 1'b0);

    // Backpressure on row 2 (pos 12 -> natural 18).
    qt_write(6'd12, 8'd10);
    send(6'd12, 16'sd5, 1'b1);
    clear_exp(); exp_v[18] = 50;
    collect("stall", 2, -1, 1'b0);

    // Block A then block B; in_valid held during A's emit must be ignored.
    qt_write(6'd5, 8'd1);
    qt_write(6'd9, 8'd1);
    send(6'd5, 16'sd7, 1'b0);
    send(6'd9, 16'sd11, 1'b1);
    clear_exp(); exp_v[2] = 7; exp_v[24] = 11;
    collect("blkA", -1, -1, 1'b1);
    send(6'd0, 16'sd3, 1'b1);
    clear_exp(); exp_v[0] = 3;
    collect("blkB", -1, -1, 1'b0);

    // Reset during row 4, then a clean block.
    send(6'd2, 16'sd1, 1'b1);
    clear_exp(); exp_v[8] = 3;
    collect("abort", -1, 4, 1'b0);
    send(6'd20, 16'sd1, 1'b1);
    clear_exp(); exp_v[40] = 128;
    collect("post_rst", -1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
